frac_tick_gen: RTL

FRAC_TICK_GEN -- requirements
Module: frac_tick_gen

---
 rtl/frac_tick_gen.sv | 138 +++++++++++++
 1 files changed

// File: rtl/frac_tick_gen.sv
// Fractional-period tick generator: emits a one-cycle TICK every
// DIV_INT + DIV_FRAC/2^FRACW clock cycles on average, plus a square wave
// that toggles on each TICK. New divisors are staged in a shadow register
// and take effect only at a period boundary, or immediately while idle.
module frac_tick_gen #(
  parameter int DIVW     = 16,
  parameter int FRACW    = 4,
  parameter int DEF_INT  = 434,
  parameter int DEF_FRAC = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [DIVW-1:0]  DIV_INT,
  input  logic [FRACW-1:0] DIV_FRAC,
  output logic             TICK,
  output logic             SQ_OUT,
  output logic             LOAD_ACK
);

  // Reset divisor, clamped to the same minimum period a LOAD would get.
  localparam logic [DIVW-1:0]  DEF_INT_C  = (DEF_INT < 2) ? DIVW'(2) : DIVW'(DEF_INT);
  localparam logic [FRACW-1:0] DEF_FRAC_C = FRACW'(DEF_FRAC);
  localparam logic [DIVW:0]    LEN_ONE    = (DIVW+1)'(1);

  typedef enum logic {
    SH_IDLE,
    SH_PEND
  } sh_state_t;

  sh_state_t        sh_state;
  sh_state_t        sh_state_nxt;

  logic [DIVW-1:0]  act_int;
  logic [FRACW-1:0] act_frac;
  logic [DIVW-1:0]  sh_int;
  logic [FRACW-1:0] sh_frac;
  logic [DIVW:0]    len;
  logic [DIVW-1:0]  cnt;
  logic [FRACW-1:0] acc;

  logic             boundary;
  logic             apply;
  logic [DIVW-1:0]  cap_int;
  logic [FRACW:0]   frac_sum;
  logic [DIVW:0]    len_nxt;
  logic             tick_r;
  logic             sq_r;
  logic             ack_r;

  // Period boundary detection, clamped capture value and next period length.
  always_comb begin
    boundary = ({1'b0, cnt} == (len - LEN_ONE));
    cap_int  = (DIV_INT < DIVW'(2)) ? DIVW'(2) : DIV_INT;
    frac_sum = {1'b0, acc} + {1'b0, act_frac};
    len_nxt  = {1'b0, act_int} + {{DIVW{1'b0}}, frac_sum[FRACW]};
  end

  // Shadow pending state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sh_state <= SH_IDLE;
    else      sh_state <= sh_state_nxt;
  end

  // Pending next-state and apply decision. A LOAD on the same edge as an
  // apply re-arms pending, so the fresh capture waits for a later boundary
  // while the apply itself uses the shadow value from before that edge.
  always_comb begin
    sh_state_nxt = sh_state;
    apply        = 1'b0;
    case (sh_state)
      SH_IDLE: begin
        if (LOAD) sh_state_nxt = SH_PEND;
      end
      SH_PEND: begin
        apply = !EN || boundary;
        if (LOAD)       sh_state_nxt = SH_PEND;
        else if (apply) sh_state_nxt = SH_IDLE;
      end
      default: sh_state_nxt = SH_IDLE;
    endcase
  end

  // Shadow divisor capture.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sh_int  <= DEF_INT_C;
      sh_frac <= DEF_FRAC_C;
    end else if (LOAD) begin
      sh_int  <= cap_int;
      sh_frac <= DIV_FRAC;
    end
  end

  // Active divisor, phase accumulator and period length update.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      act_int  <= DEF_INT_C;
      act_frac <= DEF_FRAC_C;
      acc      <= '0;
      len      <= {1'b0, DEF_INT_C};
    end else if (apply) begin
      act_int  <= sh_int;
      act_frac <= sh_frac;
      acc      <= '0;
      len      <= {1'b0, sh_int};
    end else if (EN && boundary) begin
      acc      <= frac_sum[FRACW-1:0];
      len      <= len_nxt;
    end
  end

  // Period counter: runs only while enabled, restarts at each boundary.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                 cnt <= '0;
    else if (EN && !boundary) cnt <= cnt + DIVW'(1);
    else                      cnt <= '0;
  end

  // Registered outputs: tick pulse, square wave and load acknowledge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tick_r <= 1'b0;
      sq_r   <= 1'b0;
      ack_r  <= 1'b0;
    end else begin
      tick_r <= EN && boundary;
      if (EN && boundary) sq_r <= ~sq_r;
      ack_r  <= apply;
    end
  end

  assign TICK     = tick_r;
  assign SQ_OUT   = sq_r;
  assign LOAD_ACK = ack_r;

endmodule
